// File: rtl/l1_beam_trigger.sv
// Level-1 beam trigger: 8-channel delay-and-sum beams, per-beam power threshold, windowed
// trigger-rate counters and a Wishbone register file. Define L1_TRIGGER_DEBUG_EN to export beam_metric_o.
module l1_beam_trigger #(
    parameter int              NBEAMS          = 2,
    parameter longint unsigned TRIGGER_CLOCKS  = 64'd37500000000,
    parameter int              HOLDOFF_CLOCKS  = 16,
    parameter int              START_THRESHOLD = 3500
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [21:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [31:0]       wb_dat_o,
    input  logic [7:0][95:0]  dat_i,
    output logic [NBEAMS-1:0] trigger_o
`ifdef L1_TRIGGER_DEBUG_EN
    ,
    output logic [NBEAMS-1:0][17:0] beam_metric_o
`endif
);

    localparam int CW = $clog2(TRIGGER_CLOCKS + 64'd1);
    localparam int HW = (HOLDOFF_CLOCKS < 1) ? 1 : $clog2(HOLDOFF_CLOCKS + 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(TRIGGER_CLOCKS - 64'd1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CLOCKS);
    localparam logic [17:0]   START_TH  = 18'(START_THRESHOLD);

    typedef enum logic [1:0] {WIN_IDLE, WIN_RUN, WIN_DONE} win_state_t;

    // Data path registers
    logic [7:0][95:0]   prev_dat_q, prev_dat_d;
    logic signed [14:0] beam_q [NBEAMS][8];
    logic signed [14:0] beam_d [NBEAMS][8];
    logic [17:0]        metric_q [NBEAMS];
    logic [17:0]        metric_d [NBEAMS];
    logic [NBEAMS-1:0]  trig_q, trig_d;

    // Register file and counting state
    logic [17:0]        stage_q [NBEAMS];
    logic [17:0]        stage_d [NBEAMS];
    logic [17:0]        pend_q [NBEAMS];
    logic [17:0]        pend_d [NBEAMS];
    logic [17:0]        act_q [NBEAMS];
    logic [17:0]        act_d [NBEAMS];
    logic [31:0]        count_q [NBEAMS];
    logic [31:0]        count_d [NBEAMS];
    logic [HW-1:0]      hold_q [NBEAMS];
    logic [HW-1:0]      hold_d [NBEAMS];
    win_state_t         win_q, win_d;
    logic [CW-1:0]      win_cnt_q, win_cnt_d;
    logic               wb_ack_q, wb_ack_d;
    logic [31:0]        wb_dat_q, wb_dat_d;

    // Combinational helpers
    logic signed [11:0] hist [8][16];
    logic signed [14:0] acc;
    logic [14:0]        mag;
    logic [18:0]        sum;
    logic               wb_req, wr, rd, ctrl_hit, start, apply, bhit;
    logic [1:0]         blk;
    logic [7:0]         idx;
    logic               unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[21:12], wb_adr_i[1:0]};

    // History index 8..15 is the current word, 0..7 the previous one; delay d reaches back d samples.
    always_comb begin
        prev_dat_d = dat_i;
        acc        = '0;
        for (int c = 0; c < 8; c++) begin
            for (int s = 0; s < 8; s++) begin
                hist[c][s]     = prev_dat_q[c][s*12 +: 12];
                hist[c][s + 8] = dat_i[c][s*12 +: 12];
            end
        end
        for (int b = 0; b < NBEAMS; b++) begin
            for (int s = 0; s < 8; s++) begin
                acc = '0;
                for (int c = 0; c < 8; c++) begin
                    acc = acc + 15'(hist[c][8 + s - ((b * c) % 8)]);
                end
                beam_d[b][s] = acc;
            end
        end
    end

    always_comb begin
        mag = '0;
        sum = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            sum = '0;
            for (int s = 0; s < 8; s++) begin
                mag = beam_q[b][s][14] ? 15'(-beam_q[b][s]) : 15'(beam_q[b][s]);
                sum = sum + 19'(mag);
            end
            metric_d[b] = sum[18] ? 18'h3FFFF : sum[17:0];
            trig_d[b]   = metric_q[b] > act_q[b];
        end
    end

    // Wishbone: a request is refused while its predecessor's ack is still high.
    always_comb begin
        wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_q;
        wr       = wb_req & wb_we_i;
        rd       = wb_req & ~wb_we_i;
        blk      = wb_adr_i[11:10];
        idx      = wb_adr_i[9:2];
        ctrl_hit = (blk == 2'd0) && (idx == 8'd0);
        start    = wr & ctrl_hit & wb_dat_i[0];
        apply    = wr & ctrl_hit & wb_dat_i[1];
        wb_ack_d = wb_req;
        wb_dat_d = '0;
        bhit     = 1'b0;
        if (rd && ctrl_hit) begin
            wb_dat_d = {30'd0, win_q == WIN_RUN, win_q == WIN_DONE};
        end
        for (int b = 0; b < NBEAMS; b++) begin
            stage_d[b] = stage_q[b];
            pend_d[b]  = pend_q[b];
            act_d[b]   = act_q[b];
            bhit       = (idx == 8'(b));
            if (wr && blk == 2'd1 && bhit) stage_d[b] = wb_dat_i[17:0];
            if (wr && blk == 2'd2 && bhit && wb_dat_i[0]) pend_d[b] = stage_q[b];
            if (apply) act_d[b] = pend_q[b];
            if (rd && blk == 2'd1 && bhit) wb_dat_d = count_q[b];
            if (rd && blk == 2'd2 && bhit) wb_dat_d = {14'd0, act_q[b]};
        end
    end

    // Window runs for exactly TRIGGER_CLOCKS cycles; a start write restarts it from any state.
    always_comb begin
        win_d     = win_q;
        win_cnt_d = win_cnt_q;
        case (win_q)
            WIN_RUN: begin
                if (win_cnt_q == WIN_LAST) win_d = WIN_DONE;
                else                       win_cnt_d = win_cnt_q + CW'(1);
            end
            default: ;
        endcase
        if (start) begin
            win_d     = WIN_RUN;
            win_cnt_d = '0;
        end
        for (int b = 0; b < NBEAMS; b++) begin
            count_d[b] = count_q[b];
            hold_d[b]  = (hold_q[b] != '0) ? hold_q[b] - HW'(1) : hold_q[b];
            if (start) begin
                count_d[b] = '0;
                hold_d[b]  = '0;
            end else if (win_q == WIN_RUN && trig_q[b] && hold_q[b] == '0) begin
                count_d[b] = (count_q[b] == 32'hFFFF_FFFF) ? count_q[b] : count_q[b] + 32'd1;
                hold_d[b]  = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_dat_q <= '0;
            trig_q     <= '0;
            win_q      <= WIN_IDLE;
            win_cnt_q  <= '0;
            wb_ack_q   <= 1'b0;
            wb_dat_q   <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                for (int s = 0; s < 8; s++) beam_q[b][s] <= '0;
                metric_q[b] <= '0;
                stage_q[b]  <= START_TH;
                pend_q[b]   <= START_TH;
                act_q[b]    <= START_TH;
                count_q[b]  <= '0;
                hold_q[b]   <= '0;
            end
        end else begin
            prev_dat_q <= prev_dat_d;
            trig_q     <= trig_d;
            win_q      <= win_d;
            win_cnt_q  <= win_cnt_d;
            wb_ack_q   <= wb_ack_d;
            wb_dat_q   <= wb_dat_d;
            for (int b = 0; b < NBEAMS; b++) begin
                for (int s = 0; s < 8; s++) beam_q[b][s] <= beam_d[b][s];
                metric_q[b] <= metric_d[b];
                stage_q[b]  <= stage_d[b];
                pend_q[b]   <= pend_d[b];
                act_q[b]    <= act_d[b];
                count_q[b]  <= count_d[b];
                hold_q[b]   <= hold_d[b];
            end
        end
    end

    assign trigger_o = trig_q;
    assign wb_ack_o  = wb_ack_q;
    assign wb_dat_o  = wb_dat_q;
    assign wb_err_o  = 1'b0;
    assign wb_rty_o  = 1'b0;

`ifdef L1_TRIGGER_DEBUG_EN
    always_comb begin
        for (int b = 0; b < NBEAMS; b++) beam_metric_o[b] = metric_q[b];
    end
`endif

endmodule

// File: tb/tb_l1_beam_trigger.sv
// Bench for l1_beam_trigger: random and directed ADC stimulus against an integer beamforming
// model through a trigger scoreboard, plus Wishbone register, threshold and rate-window checks.
module tb_l1_beam_trigger;

    localparam int NB = 2;
    localparam int TC = 100;
    localparam int HO = 16;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             wb_cyc_i, wb_stb_i, wb_we_i;
    logic [21:0]      wb_adr_i;
    logic [31:0]      wb_dat_i;
    logic [3:0]       wb_sel_i;
    logic             wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0]      wb_dat_o;
    logic [7:0][95:0] dat_i;
    logic [NB-1:0]    trigger_o;
`ifdef L1_TRIGGER_DEBUG_EN
    logic [NB-1:0][17:0] beam_metric_o;
`endif

    l1_beam_trigger #(
        .NBEAMS(NB), .TRIGGER_CLOCKS(64'(TC)), .HOLDOFF_CLOCKS(HO), .START_THRESHOLD(3500)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
        .dat_i(dat_i), .trigger_o(trigger_o)
`ifdef L1_TRIGGER_DEBUG_EN
        , .beam_metric_o(beam_metric_o)
`endif
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_err    = 0;
    longint      cyc_n    = 0;
    longint      wr_edge  = 0;
    logic [NB-1:0] exp_q[$];
    int          m_prev [8][8];
    int          m_stage [NB];
    int          m_pend [NB];
    int          m_act [NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge aclk) cyc_n <= cyc_n + 1;

    // Reference model: each sampled input word yields the expected trigger vector 3 clocks later.
    always @(posedge aclk) begin
        int h [8][16];
        int bs, met;
        logic [NB-1:0] e;
        if (aresetn) begin
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < 8; s++) begin
                    h[c][s]     = m_prev[c][s];
                    h[c][s + 8] = int'($signed(dat_i[c][s*12 +: 12]));
                end
            for (int b = 0; b < NB; b++) begin
                met = 0;
                for (int s = 0; s < 8; s++) begin
                    bs = 0;
                    for (int c = 0; c < 8; c++) bs += h[c][8 + s - ((b * c) % 8)];
                    met += (bs < 0) ? -bs : bs;
                end
                if (met > 262143) met = 262143;
                e[b] = met > m_act[b];
            end
            exp_q.push_back(e);
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < 8; s++) m_prev[c][s] = h[c][s + 8];
        end else begin
            exp_q.delete();
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < 8; s++) m_prev[c][s] = 0;
        end
    end

    always @(negedge aclk) begin
        logic [NB-1:0] e;
        if (aresetn && exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check("trigger_o", 64'(trigger_o), 64'(e));
        end
    end

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_stage[b] = 3500; m_pend[b] = 3500; m_act[b] = 3500;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic wb_write(input logic [21:0] adr, input logic [31:0] wdat);
        logic got;
        int   idx;
        @(negedge aclk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = wdat;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge aclk);
            got = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("wr_ack_seen", 64'(got), 64'd1);
        wr_edge = cyc_n;
        idx = int'(adr[9:2]);
        if (got) begin
            if (adr[11:10] == 2'd0 && idx == 0 && wdat[1])
                for (int b = 0; b < NB; b++) m_act[b] = m_pend[b];
            if (adr[11:10] == 2'd1 && idx < NB) m_stage[idx] = int'(wdat[17:0]);
            if (adr[11:10] == 2'd2 && idx < NB && wdat[0]) m_pend[idx] = m_stage[idx];
        end
        @(negedge aclk);
        check("wr_ack_pulse", 64'(wb_ack_o), 64'd0);
    endtask

    // Strobe is deliberately held through the ack cycle: it must not be taken as a second request.
    task automatic rd_check(input string name, input logic [21:0] adr, input logic [31:0] exp);
        logic        got;
        logic [31:0] rdat;
        @(negedge aclk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        got = 1'b0;
        rdat = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge aclk);
            got = wb_ack_o;
        end
        rdat = wb_dat_o;
        check("rd_ack_seen", 64'(got), 64'd1);
        check(name, 64'(rdat), 64'(exp));
        @(negedge aclk);
        check("rd_ack_pulse", 64'(wb_ack_o), 64'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic wait_until(input longint target);
        while (cyc_n < target) @(negedge aclk);
    endtask

    task automatic flush();
        @(negedge aclk);
        dat_i = '0;
        repeat (4) @(negedge aclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0][95:0] v;
        int amp, th0, th1;
        longint w1, w2;
        aresetn = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        dat_i = '0;
        model_reset();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Reset state
        check("trigger_reset", 64'(trigger_o), 64'd0);
        check("err_rty", 64'({wb_err_o, wb_rty_o}), 64'd0);
        rd_check("act_th0_reset", 22'h800, 32'd3500);
        rd_check("act_th1_reset", 22'h804, 32'd3500);
        rd_check("status_reset", 22'h000, 32'd0);

        // Empty window: running, then done with zero counts
        wb_write(22'h000, 32'd1);
        rd_check("status_running", 22'h000, 32'd2);
        wait_until(wr_edge + TC + 3);
        rd_check("status_done", 22'h000, 32'd1);
        rd_check("count0_empty", 22'h400, 32'd0);
        rd_check("count1_empty", 22'h404, 32'd0);

        // Impulse below default threshold, then with beam 0 threshold lowered to 500
        v = '0;
        v[0][11:0] = 12'd1000;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge aclk); dat_i = v;
            @(negedge aclk); dat_i = '0;
            @(negedge aclk);
            @(negedge aclk);
            check("impulse_trigger", 64'(trigger_o), (pass == 0) ? 64'd0 : 64'd1);
            if (pass == 0) begin
                flush();
                wb_write(22'h400, 32'd500);
                wb_write(22'h800, 32'd1);
                wb_write(22'h000, 32'd2);
                rd_check("act_th0_applied", 22'h800, 32'd500);
                rd_check("act_th1_unchanged", 22'h804, 32'd3500);
            end
        end
        flush();

        // Staging write without CE leaves pending alone; unmapped and out-of-range accesses
        wb_write(22'h400, 32'd700);
        wb_write(22'h000, 32'd2);
        rd_check("act_th0_no_ce", 22'h800, 32'd500);
        wb_write(22'h408, 32'd123);
        wb_write(22'h808, 32'd1);
        rd_check("rd_beam2_count", 22'h408, 32'd0);
        rd_check("rd_beam2_th", 22'h808, 32'd0);
        rd_check("rd_unmapped_c00", 22'hC00, 32'd0);
        rd_check("rd_unmapped_004", 22'h004, 32'd0);
        rd_check("rd_alias_high", 22'h3FF803, 32'd500);

        // Constant over-threshold input on both beams: holdoff limits the count
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 8; s++) v[c][s*12 +: 12] = 12'd100;
        @(negedge aclk); dat_i = v;
        repeat (5) @(negedge aclk);
        wb_write(22'h000, 32'd1);
        w1 = wr_edge;
        wait_until(w1 + TC + 3);
        rd_check("count0_holdoff", 22'h400, 32'd6);
        rd_check("count1_holdoff", 22'h404, 32'd6);
        rd_check("status_done2", 22'h000, 32'd1);

        // Restart mid-count
        wb_write(22'h000, 32'd1);
        w1 = wr_edge;
        wait_until(w1 + 40);
        rd_check("count0_midwin", 22'h400, 32'd3);
        flush();
        wb_write(22'h000, 32'd1);
        w2 = wr_edge;
        rd_check("status_restart", 22'h000, 32'd2);
        rd_check("count0_cleared", 22'h400, 32'd0);
        wait_until(w2 + TC - 5);
        rd_check("status_full_window", 22'h000, 32'd2);
        wait_until(w2 + TC + 3);
        rd_check("status_restart_done", 22'h000, 32'd1);
        rd_check("count1_cleared", 22'h404, 32'd0);

        // Random thresholds and random-amplitude data
        th0 = int'($urandom_range(1000, 30000));
        th1 = int'($urandom_range(1000, 30000));
        wb_write(22'h400, 32'(th0));
        wb_write(22'h404, 32'(th1));
        wb_write(22'h800, 32'd1);
        wb_write(22'h804, 32'd1);
        wb_write(22'h000, 32'd2);
        rd_check("act_th0_rand", 22'h800, 32'(th0));
        rd_check("act_th1_rand", 22'h804, 32'(th1));
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 2))
                0:       amp = 40;
                1:       amp = 250;
                default: amp = 2047;
            endcase
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < 8; s++)
                    v[c][s*12 +: 12] = 12'($urandom_range(0, 2 * amp) - amp);
            @(negedge aclk);
            dat_i = v;
        end
        flush();

        // Reset in the middle of a window
        wb_write(22'h000, 32'd1);
        repeat (10) @(negedge aclk);
        do_reset();
        rd_check("status_after_reset", 22'h000, 32'd0);
        rd_check("act_th0_after_reset", 22'h800, 32'd3500);
        rd_check("count0_after_reset", 22'h400, 32'd0);

        repeat (5) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
